// File: rtl/xs3_digit_serial_converter_pkg.sv
// rtl/xs3_digit_serial_converter_pkg.sv - shared constants and state type for the XS3/BCD converter
package xs3_pkg;

    localparam logic [3:0] XS3_OFFSET   = 4'd3;
    localparam logic       MODE_BCD2XS3 = 1'b0;
    localparam logic       MODE_XS32BCD = 1'b1;
    localparam logic [3:0] BCD_MAX      = 4'd9;
    localparam logic [3:0] XS3_MIN      = 4'd3;
    localparam logic [3:0] XS3_MAX      = 4'd12;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

endpackage

// File: rtl/xs3_digit_serial_converter_if.sv
// rtl/xs3_digit_serial_converter_if.sv - input/output word streams of the XS3/BCD converter
interface xs3_digit_serial_converter_if #(
    parameter int NDIGITS = 2
);
    logic                   in_valid;
    logic                   in_ready;
    logic [4*NDIGITS-1:0]   in_data;
    logic                   in_mode;
    logic                   out_valid;
    logic                   out_ready;
    logic [4*NDIGITS-1:0]   out_data;
    logic [NDIGITS-1:0]     out_err;
    logic                   out_mode;

    // Producer/consumer side
    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_err, out_mode
    );

    // Converter side
    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_err, out_mode
    );
endinterface

// File: rtl/xs3_digit_serial_converter_digit_conv.sv
// rtl/xs3_digit_serial_converter_digit_conv.sv - single-nibble BCD<->XS3 conversion with validity flag
module xs3_digit_conv
    import xs3_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       mode,
    output logic [3:0] result,
    output logic       invalid
);

    // Modulo-16 add/subtract of the offset; invalid digits still wrap, never clamp
    always_comb begin
        result  = digit;
        invalid = 1'b0;
        if (mode == MODE_BCD2XS3) begin
            result  = digit + XS3_OFFSET;
            invalid = (digit > BCD_MAX);
        end else begin
            result  = digit - XS3_OFFSET;
            invalid = (digit < XS3_MIN) || (digit > XS3_MAX);
        end
    end

endmodule

// File: rtl/xs3_digit_serial_converter.sv
// rtl/xs3_digit_serial_converter.sv - digit-serial BCD<->XS3 word converter on valid/ready streams
module xs3_digit_serial_converter
    import xs3_pkg::*;
#(
    parameter int NDIGITS = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    xs3_digit_serial_converter_if.slave   link
);

    localparam int W  = 4 * NDIGITS;
    localparam int CW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIGITS - 1);

    state_t          state;
    state_t          next_state;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    src;
    logic [W-1:0]    result;
    logic [NDIGITS-1:0] err;
    logic            mode;
    logic            in_ready_c;
    logic            out_valid_c;
    logic [3:0]      digit;
    logic [3:0]      digit_res;
    logic            digit_inv;

    assign digit = src[{cnt, 2'b00} +: 4];

    xs3_digit_conv u_digit_conv (
        .digit   (digit),
        .mode    (mode),
        .result  (digit_res),
        .invalid (digit_inv)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        next_state  = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (link.in_valid) next_state = CONV;
            end
            CONV: begin
                if (cnt == LAST) next_state = DONE;
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (link.out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Word capture on accept, then one digit converted per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src    <= '0;
            result <= '0;
            err    <= '0;
            mode   <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (link.in_valid) begin
                        src    <= link.in_data;
                        mode   <= link.in_mode;
                        result <= '0;
                        err    <= '0;
                        cnt    <= '0;
                    end
                end
                CONV: begin
                    result[{cnt, 2'b00} +: 4] <= digit_res;
                    err[cnt]                  <= digit_inv;
                    cnt                       <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign link.in_ready  = in_ready_c;
    assign link.out_valid = out_valid_c;
    assign link.out_data  = result;
    assign link.out_err   = err;
    assign link.out_mode  = mode;

endmodule
